vaddr_offset_issuer: RTL and testbench
======================================

Name: vaddr_offset_issuer

Overview:
- Transmit side of the vaddr offset handshake into the memops scheduler.
- Accepts one NDP command carrying up to two virtual-address offsets and drives them onto the offset/offset_valid pair consumed by the scheduler's offset collector.
- Waits for ndp_done from the NDP engine, then returns a single-cycle response with a status code.
- Sits between the host command front-end and the scheduler. Guarantees the collector never sees a duplicate second offset.

Parameters:
- GAP_CYCLES, 0: idle cycles inserted between offset A pulse and offset B pulse (0..15).
- TIMEOUT_CYCLES, 1024: cycles to wait in WAIT_DONE before declaring timeout. 0 disables the timeout.
- CNT_W, 32: width of ops_completed.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  issuer can accept a command.
- cmd_off_a  in  64  first offset.
- cmd_off_b  in  64  second offset.
- cmd_two  in  1  command carries two offsets.
- offset  out  64  offset to scheduler.
- offset_valid  out  1  single-cycle qualifier for offset.
- ndp_done  in  1  NDP operation complete; also clears the scheduler collector.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_status  out  2  00 OK, 01 TIMEOUT, 10 COLLAPSED, 11 ABORT; valid with rsp_valid.
- busy  out  1  high in every state except IDLE.
- ops_completed  out  CNT_W  count of OK plus COLLAPSED responses; wraps.

Behaviour:
- Reset (aresetn=0 at clk edge): state goes to IDLE. All outputs go to 0, including cmd_ready. All latched command registers and counters go to 0. Reset mid-operation abandons the command with no response.
- All outputs are registered.
- States: IDLE, SEND_A, GAP, SEND_B, WAIT_DONE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready: latch off_a, off_b, cmd_two. Set the collapse flag = cmd_two & (off_a==off_b). Go to SEND_A.
  - ndp_done in IDLE is ignored.
- SEND_A: offset=off_a and offset_valid=1 for exactly one cycle, the cycle after acceptance. Next state:
  - GAP if GAP_CYCLES>0 and a B pulse is needed.
  - else SEND_B if B is needed.
  - else WAIT_DONE.
  - B is needed iff cmd_two & ~collapse.
- GAP: counts GAP_CYCLES cycles with offset_valid=0, then goes to SEND_B.
- SEND_B: offset=off_b, offset_valid=1 for one cycle, then WAIT_DONE. Back-to-back timing (GAP_CYCLES=0): A pulse in cycle T+1, B pulse in T+2, where T is the accept cycle.
- offset holds its last driven value while offset_valid=0.
- WAIT_DONE: the timer clears on entry and increments each cycle.
  - ndp_done=1: go to RESP. Status is OK, or COLLAPSED if the collapse flag is set.
  - Timer reaches TIMEOUT_CYCLES-1 without ndp_done (TIMEOUT_CYCLES>0): go to RESP with TIMEOUT. ndp_done in that same cycle wins and gives OK/COLLAPSED.
- ndp_done in SEND_A, GAP or SEND_B: abort.
  - An offset_valid already registered for the current cycle is not retracted.
  - No further offsets are sent. Go to RESP with ABORT.
- RESP: rsp_valid=1 for one cycle, then IDLE.
  - Latency: ndp_done in cycle t gives rsp_valid in cycle t+1. Next command acceptance is no earlier than t+2.
  - ops_completed increments in the RESP cycle for OK or COLLAPSED only. It wraps modulo 2^CNT_W.
- cmd_ready=0 in every non-IDLE state. The command inputs are sampled only at acceptance.

Decomposition:
- Package memops_offset_pkg:
  - issuer state encoding (6 states, 3 bits).
  - rsp_status codes: ST_OK, ST_TIMEOUT, ST_COLLAPSED, ST_ABORT.
  - OFFSET_W=64.
- One sub-module: ndp_wait_timer.
  - Inputs: clear, enable. Output: expire. Parameter TIMEOUT_CYCLES.
  - Reused for the GAP count via a second instance with TIMEOUT_CYCLES=GAP_CYCLES.
- FSM, datapath registers and ops counter stay in the top module.

Test Plan:
- Two distinct offsets (a=0x1000, b=0x2000, GAP_CYCLES=0), accept at T → offset_valid at T+1 with 0x1000, at T+2 with 0x2000. ndp_done at T+10 → rsp_valid at T+11, status 00, ops_completed=1.
- cmd_two=1, a=b=0x40 → exactly one offset_valid pulse with 0x40. ndp_done → status 10, ops_completed increments.
- Single offset (cmd_two=0, a=0x80), TIMEOUT_CYCLES=16, no ndp_done → rsp_valid 16 cycles after WAIT_DONE entry, status 01, ops_completed unchanged.
- GAP_CYCLES=3, ndp_done asserted during the GAP state → no B pulse. rsp_valid next cycle with status 11. cmd_ready returns high the cycle after.
- aresetn=0 during WAIT_DONE → next cycle all outputs 0, no rsp_valid. A new command after reset is issued normally.
- Back-to-back commands with ndp_done held high in IDLE → ignored until acceptance. Verify cmd_ready=0 while busy and the offset value held between pulses.

Source files
------------

// File: rtl/memops_offset_pkg.sv
// Shared types for the vaddr offset issuer: state encoding, response codes
// and the latched command payload.
package memops_offset_pkg;

  localparam int unsigned OFFSET_W = 64;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned STATUS_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_SEND_A    = 3'd1,
    S_GAP       = 3'd2,
    S_SEND_B    = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RESP      = 3'd5
  } issuer_state_e;

  localparam logic [STATUS_W-1:0] ST_OK        = 2'b00;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT   = 2'b01;
  localparam logic [STATUS_W-1:0] ST_COLLAPSED = 2'b10;
  localparam logic [STATUS_W-1:0] ST_ABORT     = 2'b11;

  // Offset A is forwarded straight from the command bus, so only B is kept.
  typedef struct packed {
    logic [OFFSET_W-1:0] off_b;
    logic                two;
    logic                collapse;
  } issue_cmd_t;

  // Responses that count as a completed operation.
  function automatic logic status_completes(input logic [STATUS_W-1:0] st);
    return (st == ST_OK) || (st == ST_COLLAPSED);
  endfunction

endpackage

// File: rtl/ndp_wait_timer.sv
// Cycle timer: expire is high in the cycle when the count since the last
// clear reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 never expires.
module ndp_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LIMIT = ENABLED ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;

  assign count_inc = count + CW'(1);

  // expire is registered, so it is precomputed from the value count is about to take.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      expire <= ENABLED && (LIMIT == '0);
    end else if (enable) begin
      count  <= count_inc;
      expire <= ENABLED && (count_inc == LIMIT);
    end
  end

endmodule

// File: rtl/vaddr_offset_issuer.sv
// Transmit side of the vaddr offset handshake: issues one or two offset
// pulses per command, waits for ndp_done and returns a status response.
module vaddr_offset_issuer
  import memops_offset_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OFFSET_W-1:0] cmd_off_a,
  input  logic [OFFSET_W-1:0] cmd_off_b,
  input  logic                cmd_two,
  output logic [OFFSET_W-1:0] offset,
  output logic                offset_valid,
  input  logic                ndp_done,
  output logic                rsp_valid,
  output logic [STATUS_W-1:0] rsp_status,
  output logic                busy,
  output logic [CNT_W-1:0]    ops_completed
);

  localparam bit HAS_GAP = (GAP_CYCLES != 0);

  issuer_state_e state, state_d;
  issue_cmd_t    cmd_q;
  logic          accept, need_b;
  logic          gap_run, wait_run, gap_expire, wait_expire;

  logic                cmd_ready_d, busy_d, offset_valid_d, rsp_valid_d;
  logic [OFFSET_W-1:0] offset_d;
  logic [STATUS_W-1:0] rsp_status_d;
  logic [CNT_W-1:0]    ops_d;

  assign accept   = cmd_valid & cmd_ready;
  assign need_b   = cmd_q.two & ~cmd_q.collapse;
  assign gap_run  = (state == S_GAP);
  assign wait_run = (state == S_WAIT_DONE);

  ndp_wait_timer #(.TIMEOUT_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (!gap_run),
    .enable  (gap_run),
    .expire  (gap_expire)
  );

  ndp_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk     (clk),
    .aresetn (aresetn),
    .clear   (!wait_run),
    .enable  (wait_run),
    .expire  (wait_expire)
  );

  always_ff @(posedge clk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_d;
  end

  // ndp_done before WAIT_DONE aborts; in WAIT_DONE it beats a same-cycle timeout.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (accept) state_d = S_SEND_A;
      S_SEND_A: begin
        if (ndp_done)    state_d = S_RESP;
        else if (need_b) state_d = HAS_GAP ? S_GAP : S_SEND_B;
        else             state_d = S_WAIT_DONE;
      end
      S_GAP: begin
        if (ndp_done)        state_d = S_RESP;
        else if (gap_expire) state_d = S_SEND_B;
      end
      S_SEND_B:    state_d = ndp_done ? S_RESP : S_WAIT_DONE;
      S_WAIT_DONE: if (ndp_done || wait_expire) state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the state being entered.
  always_comb begin
    cmd_ready_d    = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
    offset_valid_d = 1'b0;
    offset_d       = offset;
    rsp_valid_d    = 1'b0;
    rsp_status_d   = rsp_status;
    ops_d          = ops_completed;
    case (state_d)
      S_SEND_A: begin
        offset_valid_d = 1'b1;
        offset_d       = cmd_off_a;
      end
      S_SEND_B: begin
        offset_valid_d = 1'b1;
        offset_d       = cmd_q.off_b;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        if (state == S_WAIT_DONE) begin
          if (ndp_done) rsp_status_d = cmd_q.collapse ? ST_COLLAPSED : ST_OK;
          else          rsp_status_d = ST_TIMEOUT;
        end else begin
          rsp_status_d = ST_ABORT;
        end
        if (status_completes(rsp_status_d)) ops_d = ops_completed + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      cmd_q <= '0;
    end else if (accept) begin
      cmd_q.off_b    <= cmd_off_b;
      cmd_q.two      <= cmd_two;
      cmd_q.collapse <= cmd_two && (cmd_off_a == cmd_off_b);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      offset        <= '0;
      offset_valid  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_status    <= '0;
      ops_completed <= '0;
    end else begin
      cmd_ready     <= cmd_ready_d;
      busy          <= busy_d;
      offset        <= offset_d;
      offset_valid  <= offset_valid_d;
      rsp_valid     <= rsp_valid_d;
      rsp_status    <= rsp_status_d;
      ops_completed <= ops_d;
    end
  end

endmodule

// File: tb/tb_vaddr_offset_issuer.sv
// Bench for vaddr_offset_issuer: cycle table on a no-gap instance, hand
// sequences on a GAP_CYCLES=3 instance. Both share the input stimulus.
module tb_vaddr_offset_issuer;

  logic        clk = 1'b0;
  logic        aresetn, cmd_valid, cmd_two, ndp_done;
  logic [63:0] cmd_off_a, cmd_off_b;

  logic        d0_ready, d0_ov, d0_rsp, d0_busy;
  logic [63:0] d0_off;
  logic [1:0]  d0_st;
  logic [31:0] d0_ops;
  logic        d1_ready, d1_ov, d1_rsp, d1_busy;
  logic [63:0] d1_off;
  logic [1:0]  d1_st;
  logic [31:0] d1_ops;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vaddr_offset_issuer #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(16), .CNT_W(32)) dut0 (
    .clk(clk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(d0_ready),
    .cmd_off_a(cmd_off_a), .cmd_off_b(cmd_off_b), .cmd_two(cmd_two),
    .offset(d0_off), .offset_valid(d0_ov), .ndp_done(ndp_done),
    .rsp_valid(d0_rsp), .rsp_status(d0_st), .busy(d0_busy), .ops_completed(d0_ops)
  );

  vaddr_offset_issuer #(.GAP_CYCLES(3), .TIMEOUT_CYCLES(16), .CNT_W(32)) dut1 (
    .clk(clk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(d1_ready),
    .cmd_off_a(cmd_off_a), .cmd_off_b(cmd_off_b), .cmd_two(cmd_two),
    .offset(d1_off), .offset_valid(d1_ov), .ndp_done(ndp_done),
    .rsp_valid(d1_rsp), .rsp_status(d1_st), .busy(d1_busy), .ops_completed(d1_ops)
  );

  typedef struct {
    logic        rstn, cv;
    logic [63:0] a, b;
    logic        two, done;
    logic        e_ready, e_busy, e_ov;
    logic [63:0] e_off;
    logic        e_rsp;
    logic [1:0]  e_st;
    logic [31:0] e_ops;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic rstn, input logic cv, input logic [63:0] a, input logic [63:0] b,
                      input logic two, input logic done, input logic e_ready, input logic e_busy,
                      input logic e_ov, input logic [63:0] e_off, input logic e_rsp,
                      input logic [1:0] e_st, input logic [31:0] e_ops);
    vec_t v;
    v.rstn = rstn; v.cv = cv; v.a = a; v.b = b; v.two = two; v.done = done;
    v.e_ready = e_ready; v.e_busy = e_busy; v.e_ov = e_ov; v.e_off = e_off;
    v.e_rsp = e_rsp; v.e_st = e_st; v.e_ops = e_ops;
    vq.push_back(v);
  endtask

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic cyc(input logic rstn, input logic cv, input logic [63:0] a,
                     input logic [63:0] b, input logic two, input logic done);
    @(negedge clk);
    aresetn = rstn; cmd_valid = cv; cmd_off_a = a; cmd_off_b = b; cmd_two = two; ndp_done = done;
    @(posedge clk);
    #1;
  endtask

  initial begin
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_off_a = '0; cmd_off_b = '0; cmd_two = 1'b0; ndp_done = 1'b0;

    // Each row: inputs for one cycle, outputs expected in the following cycle.
    push(0,0,0,0,0,0,               0,0,0,64'h0,    0,2'b00,0);
    push(1,0,0,0,0,0,               1,0,0,64'h0,    0,2'b00,0);
    push(1,1,'h1000,'h2000,1,0,     0,1,1,64'h1000, 0,2'b00,0);
    push(1,1,'hdead,'hbeef,0,0,     0,1,1,64'h2000, 0,2'b00,0);
    push(1,0,0,0,0,0,               0,1,0,64'h2000, 0,2'b00,0);
    for (int i = 0; i < 7; i++)
      push(1,0,0,0,0,0,             0,1,0,64'h2000, 0,2'b00,0);
    push(1,0,0,0,0,1,               0,1,0,64'h2000, 1,2'b00,1);
    push(1,0,0,0,0,0,               1,0,0,64'h2000, 0,2'b00,1);
    push(1,1,'h40,'h40,1,0,         0,1,1,64'h40,   0,2'b00,1);
    push(1,0,0,0,0,0,               0,1,0,64'h40,   0,2'b00,1);
    push(1,0,0,0,0,1,               0,1,0,64'h40,   1,2'b10,2);
    push(1,0,0,0,0,1,               1,0,0,64'h40,   0,2'b00,2);
    push(1,0,0,0,0,1,               1,0,0,64'h40,   0,2'b00,2);
    push(1,1,'h80,'h55,0,1,         0,1,1,64'h80,   0,2'b00,2);
    push(1,0,0,0,0,1,               0,1,0,64'h80,   1,2'b11,2);
    push(1,0,0,0,0,0,               1,0,0,64'h80,   0,2'b00,2);
    push(1,1,'h80,'h99,0,0,         0,1,1,64'h80,   0,2'b00,2);
    push(1,0,0,0,0,0,               0,1,0,64'h80,   0,2'b00,2);
    for (int i = 0; i < 15; i++)
      push(1,0,0,0,0,0,             0,1,0,64'h80,   0,2'b00,2);
    push(1,0,0,0,0,0,               0,1,0,64'h80,   1,2'b01,2);
    push(1,0,0,0,0,0,               1,0,0,64'h80,   0,2'b00,2);

    foreach (vq[i]) begin
      cyc(vq[i].rstn, vq[i].cv, vq[i].a, vq[i].b, vq[i].two, vq[i].done);
      chk($sformatf("v%0d cmd_ready", i), 64'(d0_ready), 64'(vq[i].e_ready));
      chk($sformatf("v%0d busy", i), 64'(d0_busy), 64'(vq[i].e_busy));
      chk($sformatf("v%0d offset_valid", i), 64'(d0_ov), 64'(vq[i].e_ov));
      chk($sformatf("v%0d offset", i), d0_off, vq[i].e_off);
      chk($sformatf("v%0d rsp_valid", i), 64'(d0_rsp), 64'(vq[i].e_rsp));
      chk($sformatf("v%0d ops_completed", i), 64'(d0_ops), 64'(vq[i].e_ops));
      if (vq[i].e_rsp) chk($sformatf("v%0d rsp_status", i), 64'(d0_st), 64'(vq[i].e_st));
    end

    // GAP_CYCLES=3: full two-offset issue, B pulse four cycles after A.
    cyc(0,0,0,0,0,0);
    chk("g reset ready", 64'(d1_ready), 64'h0);
    cyc(1,0,0,0,0,0);
    chk("g ready", 64'(d1_ready), 64'h1);
    cyc(1,1,'h100,'h200,1,0);
    chk("g A valid", 64'(d1_ov), 64'h1);
    chk("g A offset", d1_off, 64'h100);
    for (int i = 0; i < 3; i++) begin
      cyc(1,0,0,0,0,0);
      chk($sformatf("g gap%0d valid", i), 64'(d1_ov), 64'h0);
      chk($sformatf("g gap%0d offset held", i), d1_off, 64'h100);
    end
    cyc(1,0,0,0,0,0);
    chk("g B valid", 64'(d1_ov), 64'h1);
    chk("g B offset", d1_off, 64'h200);
    cyc(1,0,0,0,0,0);
    chk("g wait valid", 64'(d1_ov), 64'h0);
    chk("g wait busy", 64'(d1_busy), 64'h1);

    // Reset while waiting for ndp_done: everything clears, no response.
    cyc(0,0,0,0,0,0);
    chk("r ready", 64'(d1_ready), 64'h0);
    chk("r busy", 64'(d1_busy), 64'h0);
    chk("r valid", 64'(d1_ov), 64'h0);
    chk("r offset", d1_off, 64'h0);
    chk("r rsp", 64'(d1_rsp), 64'h0);
    chk("r ops", 64'(d1_ops), 64'h0);
    cyc(1,0,0,0,0,0);
    chk("r rsp after", 64'(d1_rsp), 64'h0);
    chk("r ready after", 64'(d1_ready), 64'h1);
    cyc(1,1,'h300,'h0,0,0);
    chk("r new A valid", 64'(d1_ov), 64'h1);
    chk("r new A offset", d1_off, 64'h300);
    cyc(1,0,0,0,0,0);
    cyc(1,0,0,0,0,1);
    chk("r new rsp", 64'(d1_rsp), 64'h1);
    chk("r new status", 64'(d1_st), 64'h0);
    chk("r new ops", 64'(d1_ops), 64'h1);
    cyc(1,0,0,0,0,0);
    chk("r new idle", 64'(d1_ready), 64'h1);

    // ndp_done during GAP: no B pulse, abort response next cycle.
    cyc(1,1,'h100,'h200,1,0);
    chk("a A valid", 64'(d1_ov), 64'h1);
    cyc(1,0,0,0,0,0);
    chk("a gap valid", 64'(d1_ov), 64'h0);
    cyc(1,0,0,0,0,1);
    chk("a rsp", 64'(d1_rsp), 64'h1);
    chk("a status", 64'(d1_st), 64'h3);
    chk("a no B", 64'(d1_ov), 64'h0);
    chk("a offset", d1_off, 64'h100);
    chk("a ops", 64'(d1_ops), 64'h1);
    chk("a ready in resp", 64'(d1_ready), 64'h0);
    cyc(1,0,0,0,0,0);
    chk("a ready", 64'(d1_ready), 64'h1);
    chk("a rsp single", 64'(d1_rsp), 64'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1,0,0,0,0,0);
      chk($sformatf("a quiet%0d", i), 64'(d1_ov), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
